alu16_unit: RTL and testbench
=============================

Name: alu16_unit

Overview:
- Multi-cycle 16-bit arithmetic unit for the CPU: ADD HL,rr; ADD SP,e8 / LD HL,SP+e8; INC rr; DEC rr.
- Computes in two 8-bit halves (low byte, then high byte with latched carry).
- Feeds the 8-bit ALU: its flag output drives that ALU's external-flags input, and its save-flags strobe drives that ALU's save-flags input.
- Result goes to the 16-bit register write-back path.

Parameters:
- None.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_n  input  1  reset; one clock, asynchronous, active-low.
- i_Enable  input  1  clock enable; when low, all state holds.
- i_Start  input  1  request a new operation; sampled only in IDLE with i_Enable high.
- i_Mode  input  2  operation select: 00 ADD16, 01 ADD_E8, 10 INC16, 11 DEC16.
- i_Base  input  16  HL for ADD16, SP for ADD_E8, rr for INC16/DEC16.
- i_Operand  input  16  rr for ADD16; bits 7:0 = signed e8 for ADD_E8; ignored otherwise.
- i_Flags  input  4  current {Z,N,H,C} from the flags register.
- o_Busy  output  1  high from start accept until the cycle after o_Done.
- o_Done  output  1  one-cycle pulse; o_Result is valid.
- o_Result  output  16  result; held until the next accepted start.
- o_Flags  output  4  {Z,N,H,C}; non-zero only while o_Done is high.
- o_Save_Flags  output  1  high with o_Done when the mode updates flags.

Behaviour:
- Reset values:
  - State = IDLE.
  - o_Busy, o_Done, o_Save_Flags = 0; o_Flags = 4'h0; o_Result = 16'h0000.
  - Latched operands and carry = 0.
- State machine (each transition only on a clock edge with i_Enable=1):
  - IDLE: if i_Start, latch i_Mode, i_Base, i_Operand and i_Flags[3] (Z); o_Busy<=1; go to LOW.
  - LOW: low = base[7:0] + opB[7:0]; latch carry-out of bit 3 (h_lo) and bit 7 (c_lo); go to HIGH.
  - HIGH: high = base[15:8] + opB[15:8] + c_lo; latch carry-out of bit 11 (H16) and bit 15 (C16); go to DONE.
  - DONE: o_Done=1, o_Result valid, flags presented; next state IDLE with o_Busy<=0.
- Operand B per mode:
  - ADD16: i_Operand.
  - ADD_E8: sign-extended i_Operand[7:0].
  - INC16: 16'h0001.
  - DEC16: 16'hFFFF.
- Arithmetic is modulo 2^16; wrap-around is silent.
- Latency: start accepted at edge N → o_Done high during cycle N+3, given continuous enable.
- i_Enable low stretches every state; outputs hold.
- o_Done and flags remain high across an enable stall until one enabled edge passes.
- Flags, driven only in DONE:
  - ADD16: Z = latched Z, N=0, H=H16, C=C16; o_Save_Flags=1.
  - ADD_E8: Z=0, N=0, H=h_lo, C=c_lo (unsigned low-byte carries, sign ignored); o_Save_Flags=1.
  - INC16/DEC16: o_Flags=0, o_Save_Flags=0.
- Outside DONE, o_Flags=0 so the OR-combined flag bus downstream is undisturbed.
- i_Start while not in IDLE is ignored, including in the DONE cycle; there is no queue.
- i_Rst_n asserted mid-operation: immediate return to reset values; the partial result is discarded.
- Input changes after start acceptance have no effect on the operation.

Optional Feature:
- Macro: ALU16_SINGLE_CYCLE_EN.
- Defined:
  - The LOW state computes the full 16-bit sum and all four carries, then goes directly to DONE.
  - The HIGH state does not exist; latency is N+2.
  - Flag and result values are identical to the non-macro build.
- Undefined: the two-half-cycle flow above, latency N+3.

Test Plan:
- ADD16, base 16'h0FFF, operand 16'h0001, i_Flags=4'b1000 → o_Result=16'h1000, o_Flags=4'b1010, o_Save_Flags=1, o_Done at cycle N+3 (N+2 with the macro).
- ADD16, base 16'hFFFF, operand 16'h0001, i_Flags=4'b0000 → o_Result=16'h0000, o_Flags=4'b0011.
- ADD_E8, base 16'hFFF8, e8 8'h08 → 16'h0000, flags 4'b0011. ADD_E8, base 16'h0005, e8 8'hFF → 16'h0004, flags 4'b0011. ADD_E8, base 16'h1000, e8 8'h80 → 16'h0F80, flags 4'b0000.
- DEC16, base 16'h0000 → 16'hFFFF, o_Save_Flags=0, o_Flags=0. INC16, base 16'hFFFF → 16'h0000, o_Save_Flags=0, o_Flags=0.
- Start ADD16; pulse i_Start with a different mode while busy → ignored, first result unchanged. Hold i_Enable low 5 cycles in HIGH → o_Done delayed by exactly 5 cycles.
- Assert i_Rst_n low during LOW → o_Busy=0, o_Result=16'h0000 asynchronously. A new start after release completes normally.

Source files
------------

// File: rtl/alu16_unit.sv
// Multi-cycle 16-bit adder for ADD HL,rr / ADD SP,e8 / INC rr / DEC rr, computed as two byte halves.
// Define ALU16_SINGLE_CYCLE_EN to compute the whole sum in one state (LOW -> DONE).
module alu16_unit (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Enable,
  input  logic        i_Start,
  input  logic [1:0]  i_Mode,
  input  logic [15:0] i_Base,
  input  logic [15:0] i_Operand,
  input  logic [3:0]  i_Flags,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [15:0] o_Result,
  output logic [3:0]  o_Flags,
  output logic        o_Save_Flags
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOW,
`ifndef ALU16_SINGLE_CYCLE_EN
    S_HIGH,
`endif
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    MODE_ADD16  = 2'b00,
    MODE_ADD_E8 = 2'b01,
    MODE_INC16  = 2'b10,
    MODE_DEC16  = 2'b11
  } mode_e;

  state_e      state_q, state_d;
  mode_e       mode_q, mode_d;
  logic [15:0] base_q, base_d;
  logic [15:0] opnd_q, opnd_d;
  logic        z_q, z_d;
  logic        h_lo_q, h_lo_d;
  logic        c_lo_q, c_lo_d;
  logic        h16_q, h16_d;
  logic        c16_q, c16_d;
  logic [15:0] result_q, result_d;
  logic        busy_q, busy_d;
`ifndef ALU16_SINGLE_CYCLE_EN
  logic [7:0]  lo_q, lo_d;
`endif

  logic [15:0] opb;
  logic [8:0]  lo_sum;
  logic [4:0]  lo_nib;
  logic        hi_cin;
  logic [8:0]  hi_sum;
  logic [4:0]  hi_nib;
  logic        flags_unused;

  // Only Z is carried through; N/H/C are always recomputed.
  assign flags_unused = ^i_Flags[2:0];

  always_comb begin
    opb = 16'h0000;
    unique case (mode_q)
      MODE_ADD16:  opb = opnd_q;
      MODE_ADD_E8: opb = {{8{opnd_q[7]}}, opnd_q[7:0]};
      MODE_INC16:  opb = 16'h0001;
      MODE_DEC16:  opb = '1;
      default:     opb = 16'h0000;
    endcase
  end

  assign lo_sum = {1'b0, base_q[7:0]} + {1'b0, opb[7:0]};
  assign lo_nib = {1'b0, base_q[3:0]} + {1'b0, opb[3:0]};
`ifdef ALU16_SINGLE_CYCLE_EN
  assign hi_cin = lo_sum[8];
`else
  assign hi_cin = c_lo_q;
`endif
  assign hi_sum = {1'b0, base_q[15:8]} + {1'b0, opb[15:8]} + {8'h00, hi_cin};
  assign hi_nib = {1'b0, base_q[11:8]} + {1'b0, opb[11:8]} + {4'h0, hi_cin};

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    base_d   = base_q;
    opnd_d   = opnd_q;
    z_d      = z_q;
    h_lo_d   = h_lo_q;
    c_lo_d   = c_lo_q;
    h16_d    = h16_q;
    c16_d    = c16_q;
    result_d = result_q;
    busy_d   = busy_q;
`ifndef ALU16_SINGLE_CYCLE_EN
    lo_d     = lo_q;
`endif
    if (i_Enable) begin
      unique case (state_q)
        S_IDLE: begin
          if (i_Start) begin
            mode_d  = mode_e'(i_Mode);
            base_d  = i_Base;
            opnd_d  = i_Operand;
            z_d     = i_Flags[3];
            busy_d  = 1'b1;
            state_d = S_LOW;
          end
        end
        S_LOW: begin
          h_lo_d = lo_nib[4];
          c_lo_d = lo_sum[8];
`ifdef ALU16_SINGLE_CYCLE_EN
          h16_d    = hi_nib[4];
          c16_d    = hi_sum[8];
          result_d = {hi_sum[7:0], lo_sum[7:0]};
          state_d  = S_DONE;
`else
          lo_d    = lo_sum[7:0];
          state_d = S_HIGH;
`endif
        end
`ifndef ALU16_SINGLE_CYCLE_EN
        S_HIGH: begin
          h16_d    = hi_nib[4];
          c16_d    = hi_sum[8];
          result_d = {hi_sum[7:0], lo_q};
          state_d  = S_DONE;
        end
`endif
        S_DONE: begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= MODE_ADD16;
      base_q   <= '0;
      opnd_q   <= '0;
      z_q      <= 1'b0;
      h_lo_q   <= 1'b0;
      c_lo_q   <= 1'b0;
      h16_q    <= 1'b0;
      c16_q    <= 1'b0;
      result_q <= '0;
      busy_q   <= 1'b0;
`ifndef ALU16_SINGLE_CYCLE_EN
      lo_q     <= '0;
`endif
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      base_q   <= base_d;
      opnd_q   <= opnd_d;
      z_q      <= z_d;
      h_lo_q   <= h_lo_d;
      c_lo_q   <= c_lo_d;
      h16_q    <= h16_d;
      c16_q    <= c16_d;
      result_q <= result_d;
      busy_q   <= busy_d;
`ifndef ALU16_SINGLE_CYCLE_EN
      lo_q     <= lo_d;
`endif
    end
  end

  // Flags are zero outside DONE so the downstream OR-combined flag bus is undisturbed.
  always_comb begin
    o_Flags      = 4'h0;
    o_Save_Flags = 1'b0;
    if (state_q == S_DONE) begin
      unique case (mode_q)
        MODE_ADD16: begin
          o_Flags      = {z_q, 1'b0, h16_q, c16_q};
          o_Save_Flags = 1'b1;
        end
        MODE_ADD_E8: begin
          o_Flags      = {1'b0, 1'b0, h_lo_q, c_lo_q};
          o_Save_Flags = 1'b1;
        end
        default: begin
          o_Flags      = 4'h0;
          o_Save_Flags = 1'b0;
        end
      endcase
    end
  end

  assign o_Busy   = busy_q;
  assign o_Done   = (state_q == S_DONE);
  assign o_Result = result_q;

endmodule

// File: tb/tb_alu16_unit.sv
// Directed-vector bench for alu16_unit; honours ALU16_SINGLE_CYCLE_EN for latency expectations.
module tb_alu16_unit;

`ifdef ALU16_SINGLE_CYCLE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        i_Clk;
  logic        i_Rst_n;
  logic        i_Enable;
  logic        i_Start;
  logic [1:0]  i_Mode;
  logic [15:0] i_Base;
  logic [15:0] i_Operand;
  logic [3:0]  i_Flags;
  logic        o_Busy;
  logic        o_Done;
  logic [15:0] o_Result;
  logic [3:0]  o_Flags;
  logic        o_Save_Flags;

  int n_vec;
  int n_err;

  alu16_unit dut (
    .i_Clk        (i_Clk),
    .i_Rst_n      (i_Rst_n),
    .i_Enable     (i_Enable),
    .i_Start      (i_Start),
    .i_Mode       (i_Mode),
    .i_Base       (i_Base),
    .i_Operand    (i_Operand),
    .i_Flags      (i_Flags),
    .o_Busy       (o_Busy),
    .o_Done       (o_Done),
    .o_Result     (o_Result),
    .o_Flags      (o_Flags),
    .o_Save_Flags (o_Save_Flags)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (o_Done !== 1'b1 && cyc < 30) begin
      @(posedge i_Clk); #1;
      cyc++;
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] m, input logic [15:0] b,
                       input logic [15:0] op, input logic [3:0] f, input logic [15:0] exp_r,
                       input logic [3:0] exp_f, input logic exp_s);
    int cyc;
    @(negedge i_Clk);
    i_Mode = m; i_Base = b; i_Operand = op; i_Flags = f; i_Start = 1'b1;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    check({tag, " busy"}, o_Busy, 1);
    wait_done(cyc);
    check({tag, " latency"}, cyc, LAT);
    check({tag, " result"}, o_Result, exp_r);
    check({tag, " flags"}, o_Flags, exp_f);
    check({tag, " save"}, o_Save_Flags, exp_s);
    @(posedge i_Clk); #1;
    check({tag, " post done"}, {o_Busy, o_Done, o_Save_Flags, o_Flags}, 0);
    check({tag, " held"}, o_Result, exp_r);
  endtask

  initial begin
    int cyc;
    n_vec = 0; n_err = 0;
    i_Rst_n = 1'b0; i_Enable = 1'b1; i_Start = 1'b0;
    i_Mode = 2'b00; i_Base = 16'h0; i_Operand = 16'h0; i_Flags = 4'h0;
    #3;
    check("reset outputs", {o_Busy, o_Done, o_Save_Flags, o_Flags}, 0);
    check("reset result", o_Result, 0);
    @(negedge i_Clk); i_Rst_n = 1'b1;

    do_op("add16 half carry", 2'b00, 16'h0FFF, 16'h0001, 4'b1000, 16'h1000, 4'b1010, 1'b1);
    do_op("add16 wrap",       2'b00, 16'hFFFF, 16'h0001, 4'b0000, 16'h0000, 4'b0011, 1'b1);
    do_op("add16 plain",      2'b00, 16'h1234, 16'h4321, 4'b1111, 16'h5555, 4'b1000, 1'b1);
    do_op("adde8 +8",         2'b01, 16'hFFF8, 16'h0008, 4'b1000, 16'h0000, 4'b0011, 1'b1);
    do_op("adde8 -1",         2'b01, 16'h0005, 16'h00FF, 4'b0000, 16'h0004, 4'b0011, 1'b1);
    do_op("adde8 -128",       2'b01, 16'h1000, 16'hAB80, 4'b1111, 16'h0F80, 4'b0000, 1'b1);
    do_op("dec16 wrap",       2'b11, 16'h0000, 16'h1234, 4'b1111, 16'hFFFF, 4'b0000, 1'b0);
    do_op("inc16 wrap",       2'b10, 16'hFFFF, 16'h5678, 4'b1111, 16'h0000, 4'b0000, 1'b0);
    do_op("inc16 plain",      2'b10, 16'h00FF, 16'h0000, 4'b0000, 16'h0100, 4'b0000, 1'b0);

    // Start ignored while busy, and inputs changed after acceptance.
    @(negedge i_Clk);
    i_Mode = 2'b00; i_Base = 16'h0FFF; i_Operand = 16'h0001; i_Flags = 4'b1000; i_Start = 1'b1;
    @(posedge i_Clk); #1;
    i_Mode = 2'b10; i_Base = 16'h1234; i_Operand = 16'h7777; i_Flags = 4'b0000;
    wait_done(cyc);
    check("ignore latency", cyc, LAT);
    check("ignore result", o_Result, 16'h1000);
    check("ignore flags", o_Flags, 4'b1010);
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    check("start in done ignored", {o_Busy, o_Done}, 0);
    @(posedge i_Clk); #1;
    check("still idle", {o_Busy, o_Done}, 0);
    check("ignore held", o_Result, 16'h1000);

    // Enable stall of 5 cycles mid-operation, then stall in DONE.
    @(negedge i_Clk);
    i_Mode = 2'b00; i_Base = 16'hFFFF; i_Operand = 16'h0001; i_Flags = 4'b0000; i_Start = 1'b1;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    cyc = 0;
`ifndef ALU16_SINGLE_CYCLE_EN
    @(posedge i_Clk); #1;
    cyc++;
`endif
    i_Enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge i_Clk); #1;
      cyc++;
    end
    check("stall busy", {o_Busy, o_Done}, 2'b10);
    i_Enable = 1'b1;
    while (o_Done !== 1'b1 && cyc < 30) begin
      @(posedge i_Clk); #1;
      cyc++;
    end
    check("stall latency", cyc, LAT + 5);
    check("stall result", o_Result, 16'h0000);
    i_Enable = 1'b0;
    @(posedge i_Clk); #1;
    @(posedge i_Clk); #1;
    check("done held in stall", {o_Done, o_Save_Flags, o_Flags}, 6'b110011);
    i_Enable = 1'b1;
    @(posedge i_Clk); #1;
    check("done released", {o_Busy, o_Done, o_Flags}, 0);

    // Asynchronous reset during LOW.
    do_op("pre reset", 2'b00, 16'h1111, 16'h2222, 4'b0000, 16'h3333, 4'b0000, 1'b1);
    @(negedge i_Clk);
    i_Mode = 2'b00; i_Base = 16'h0FFF; i_Operand = 16'h0001; i_Start = 1'b1;
    @(posedge i_Clk); #1;
    i_Start = 1'b0;
    #2 i_Rst_n = 1'b0;
    #1;
    check("async reset busy", {o_Busy, o_Done}, 0);
    check("async reset result", o_Result, 0);
    @(negedge i_Clk); i_Rst_n = 1'b1;
    do_op("after reset", 2'b01, 16'hFFF8, 16'h0008, 4'b0000, 16'h0000, 4'b0011, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
